// File: rtl/mem_bus_arbiter.sv
// Two-master round-robin arbiter for the MiniRISC 8-bit data-memory bus.
// Grants are combinational; a bounded lock lets the current owner extend a streak.
module mem_bus_arbiter #(
  parameter int MAX_HOLD = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       m0_req,
  input  logic       m1_req,
  input  logic       m0_lock,
  input  logic       m1_lock,
  input  logic       m0_wr,
  input  logic       m1_wr,
  input  logic       m0_rd,
  input  logic       m1_rd,
  input  logic [7:0] m0_addr,
  input  logic [7:0] m1_addr,
  input  logic [7:0] m0_wdata,
  input  logic [7:0] m1_wdata,
  output logic       m0_gnt,
  output logic       m1_gnt,
  output logic       bus_wr,
  output logic       bus_rd,
  output logic [7:0] bus_addr,
  output logic [7:0] bus_wdata,
  input  logic [7:0] bus_rdata,
  output logic [7:0] m_rdata,
  output logic [7:0] conflict_cnt,
  output logic       last_owner
);
  localparam int HW = $clog2(MAX_HOLD + 1);

  logic [1:0]    req, lock, gnt;
  logic          last, keep, win;
  logic [HW-1:0] hold_cnt;

  assign req  = {m1_req, m0_req};
  assign lock = {m1_lock, m0_lock};

  // Lock only extends an unbroken streak (hold_cnt != 0) and only up to MAX_HOLD.
  always_comb begin
    keep = lock[last] && (hold_cnt != '0) && (hold_cnt < HW'(MAX_HOLD));
    win  = keep ? last : ~last;
    gnt  = 2'b00;
    if (!rst) begin
      case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = win ? 2'b10 : 2'b01;
        default: gnt = 2'b00;
      endcase
    end
  end

  assign m0_gnt     = gnt[0];
  assign m1_gnt     = gnt[1];
  assign bus_wr     = (gnt[0] & m0_wr) | (gnt[1] & m1_wr);
  assign bus_rd     = (gnt[0] & m0_rd) | (gnt[1] & m1_rd);
  assign bus_addr   = ({8{gnt[0]}} & m0_addr)  | ({8{gnt[1]}} & m1_addr);
  assign bus_wdata  = ({8{gnt[0]}} & m0_wdata) | ({8{gnt[1]}} & m1_wdata);
  assign m_rdata    = bus_rdata;
  assign last_owner = last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last         <= 1'b1;
      hold_cnt     <= '0;
      conflict_cnt <= 8'd0;
    end else begin
      if (gnt == 2'b00) begin
        hold_cnt <= '0;
      end else if (gnt[1] == last) begin
        if (hold_cnt < HW'(MAX_HOLD)) hold_cnt <= hold_cnt + HW'(1);
      end else begin
        hold_cnt <= HW'(1);
        last     <= gnt[1];
      end
      if ((&req) && (conflict_cnt != 8'hFF)) conflict_cnt <= conflict_cnt + 8'd1;
    end
  end
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: per-cycle vector table plus reset/saturation sequences.
module tb_mem_bus_arbiter;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       m0_req = 0, m1_req = 0, m0_lock = 0, m1_lock = 0;
  logic       m0_wr = 0, m1_wr = 0, m0_rd = 0, m1_rd = 0;
  logic [7:0] m0_addr = 0, m1_addr = 0, m0_wdata = 0, m1_wdata = 0, bus_rdata = 0;
  logic       m0_gnt, m1_gnt, bus_wr, bus_rd, last_owner;
  logic [7:0] bus_addr, bus_wdata, m_rdata, conflict_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_bus_arbiter #(.MAX_HOLD(4)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m1_req(m1_req), .m0_lock(m0_lock), .m1_lock(m1_lock),
    .m0_wr(m0_wr), .m1_wr(m1_wr), .m0_rd(m0_rd), .m1_rd(m1_rd),
    .m0_addr(m0_addr), .m1_addr(m1_addr), .m0_wdata(m0_wdata), .m1_wdata(m1_wdata),
    .m0_gnt(m0_gnt), .m1_gnt(m1_gnt), .bus_wr(bus_wr), .bus_rd(bus_rd),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata),
    .m_rdata(m_rdata), .conflict_cnt(conflict_cnt), .last_owner(last_owner)
  );

  // rb: pulse reset before this cycle; gnt/req/lock/wr/rd are {m1,m0}.
  typedef struct packed {
    logic       rb;
    logic [1:0] req, lock, wr, rd;
    logic [7:0] a0, d0, a1, d1, rdata;
    logic [1:0] gnt;
    logic       bwr, brd;
    logic [7:0] baddr, bwdata, cnt;
    logic       last;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    logic [36:0] act, exp;
    if (v.rb) pulse_reset();
    else @(negedge clk);
    {m1_req, m0_req}   = v.req;
    {m1_lock, m0_lock} = v.lock;
    {m1_wr, m0_wr}     = v.wr;
    {m1_rd, m0_rd}     = v.rd;
    m0_addr = v.a0; m0_wdata = v.d0; m1_addr = v.a1; m1_wdata = v.d1;
    bus_rdata = v.rdata;
    #1;
    act = {m1_gnt, m0_gnt, bus_wr, bus_rd, bus_addr, bus_wdata, m_rdata, conflict_cnt, last_owner};
    exp = {v.gnt, v.bwr, v.brd, v.baddr, v.bwdata, v.rdata, v.cnt, v.last};
    chk($sformatf("vec[%0d] {gnt,wr,rd,addr,wdata,rdata,cnt,last}", idx), 64'(act), 64'(exp));
  endtask

  initial begin
    // rb req lock wr rd a0 d0 a1 d1 rdata | gnt bwr brd baddr bwdata cnt last
    vecs.push_back(vec_t'{1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 2'b00, 1'b0, 1'b0, 8'h00, 8'h00, 8'd0, 1'b1});
    // single CPU read
    vecs.push_back(vec_t'{1'b0, 2'b01, 2'b00, 2'b00, 2'b01, 8'h10, 8'h00, 8'h00, 8'h00, 8'h5A, 2'b01, 1'b0, 1'b1, 8'h10, 8'h00, 8'd0, 1'b1});
    vecs.push_back(vec_t'{1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 2'b00, 1'b0, 1'b0, 8'h00, 8'h00, 8'd0, 1'b0});
    // idle master's strobes must not leak onto the bus
    vecs.push_back(vec_t'{1'b0, 2'b01, 2'b00, 2'b10, 2'b01, 8'h11, 8'h00, 8'h99, 8'hEE, 8'h12, 2'b01, 1'b0, 1'b1, 8'h11, 8'h00, 8'd0, 1'b0});
    // round-robin from reset
    vecs.push_back(vec_t'{1'b1, 2'b11, 2'b00, 2'b01, 2'b10, 8'h20, 8'hA5, 8'h30, 8'h00, 8'hC3, 2'b01, 1'b1, 1'b0, 8'h20, 8'hA5, 8'd0, 1'b1});
    vecs.push_back(vec_t'{1'b0, 2'b11, 2'b00, 2'b01, 2'b10, 8'h20, 8'hA5, 8'h30, 8'h00, 8'hC3, 2'b10, 1'b0, 1'b1, 8'h30, 8'h00, 8'd1, 1'b0});
    vecs.push_back(vec_t'{1'b0, 2'b11, 2'b00, 2'b01, 2'b10, 8'h20, 8'hA5, 8'h30, 8'h00, 8'hC3, 2'b01, 1'b1, 1'b0, 8'h20, 8'hA5, 8'd2, 1'b1});
    vecs.push_back(vec_t'{1'b0, 2'b11, 2'b00, 2'b01, 2'b10, 8'h20, 8'hA5, 8'h30, 8'h00, 8'hC3, 2'b10, 1'b0, 1'b1, 8'h30, 8'h00, 8'd3, 1'b0});
    vecs.push_back(vec_t'{1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 2'b00, 1'b0, 1'b0, 8'h00, 8'h00, 8'd4, 1'b1});
    // bounded lock: m1 alone, then 3 more locked cycles, m0 once, m1 again
    vecs.push_back(vec_t'{1'b1, 2'b10, 2'b10, 2'b10, 2'b00, 8'h00, 8'h00, 8'h40, 8'h77, 8'h00, 2'b10, 1'b1, 1'b0, 8'h40, 8'h77, 8'd0, 1'b1});
    vecs.push_back(vec_t'{1'b0, 2'b11, 2'b10, 2'b10, 2'b01, 8'h50, 8'h00, 8'h40, 8'h77, 8'h00, 2'b10, 1'b1, 1'b0, 8'h40, 8'h77, 8'd0, 1'b1});
    vecs.push_back(vec_t'{1'b0, 2'b11, 2'b10, 2'b10, 2'b01, 8'h50, 8'h00, 8'h40, 8'h77, 8'h00, 2'b10, 1'b1, 1'b0, 8'h40, 8'h77, 8'd1, 1'b1});
    vecs.push_back(vec_t'{1'b0, 2'b11, 2'b10, 2'b10, 2'b01, 8'h50, 8'h00, 8'h40, 8'h77, 8'h00, 2'b10, 1'b1, 1'b0, 8'h40, 8'h77, 8'd2, 1'b1});
    vecs.push_back(vec_t'{1'b0, 2'b11, 2'b10, 2'b10, 2'b01, 8'h50, 8'h00, 8'h40, 8'h77, 8'h00, 2'b01, 1'b0, 1'b1, 8'h50, 8'h00, 8'd3, 1'b1});
    vecs.push_back(vec_t'{1'b0, 2'b11, 2'b10, 2'b10, 2'b01, 8'h50, 8'h00, 8'h40, 8'h77, 8'h00, 2'b10, 1'b1, 1'b0, 8'h40, 8'h77, 8'd4, 1'b0});
    vecs.push_back(vec_t'{1'b0, 2'b11, 2'b10, 2'b10, 2'b01, 8'h50, 8'h00, 8'h40, 8'h77, 8'h00, 2'b10, 1'b1, 1'b0, 8'h40, 8'h77, 8'd5, 1'b1});
    // lock cannot reclaim the bus after an idle cycle
    vecs.push_back(vec_t'{1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 2'b00, 1'b0, 1'b0, 8'h00, 8'h00, 8'd6, 1'b1});
    vecs.push_back(vec_t'{1'b0, 2'b11, 2'b10, 2'b10, 2'b01, 8'h50, 8'h00, 8'h40, 8'h77, 8'h00, 2'b01, 1'b0, 1'b1, 8'h50, 8'h00, 8'd6, 1'b1});

    foreach (vecs[i]) run_vec(vecs[i], i);

    // saturation over 300 contended cycles
    pulse_reset();
    {m1_req, m0_req} = 2'b11; {m1_lock, m0_lock} = 2'b00;
    {m1_wr, m0_wr} = 2'b00; {m1_rd, m0_rd} = 2'b11;
    repeat (254) @(posedge clk);
    @(negedge clk); #1;
    chk("sat cnt@254", 64'(conflict_cnt), 64'd254);
    repeat (46) @(posedge clk);
    @(negedge clk); #1;
    chk("sat cnt@300", 64'(conflict_cnt), 64'd255);
    @(negedge clk); #1;
    chk("sat cnt hold", 64'(conflict_cnt), 64'd255);

    // reset asserted mid-burst while m1 owns the bus and writes
    pulse_reset();
    {m1_req, m0_req} = 2'b10; {m1_lock, m0_lock} = 2'b10;
    {m1_wr, m0_wr} = 2'b10; {m1_rd, m0_rd} = 2'b01;
    m1_addr = 8'h60; m1_wdata = 8'h33; m0_addr = 8'h70; m0_wdata = 8'h00;
    #1;
    chk("burst m1 gnt,wr", 64'({m1_gnt, m0_gnt, bus_wr}), 64'(3'b101));
    @(negedge clk);
    m0_req = 1'b1;
    @(negedge clk);
    @(negedge clk); #1;
    chk("burst locked gnt,cnt", 64'({m1_gnt, m0_gnt, conflict_cnt}), 64'({2'b10, 8'd2}));
    #2 rst = 1'b1;
    #1;
    chk("rst mid gnt,wr,rd,addr,wdata", 64'({m1_gnt, m0_gnt, bus_wr, bus_rd, bus_addr, bus_wdata}), 64'd0);
    chk("rst mid cnt,last", 64'({conflict_cnt, last_owner}), 64'({8'd0, 1'b1}));
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post-rst first gnt", 64'({m1_gnt, m0_gnt}), 64'(2'b01));
    @(negedge clk); #1;
    chk("post-rst cnt,gnt", 64'({conflict_cnt, m1_gnt, m0_gnt}), 64'({8'd1, 2'b10}));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
